axi4s_video_frame_normalizer: RTL and testbench

//  Sits between the camera AXI4-Stream image input and the image-processing pipeline (Gaussian/LK stages).

---
 rtl/axi4s_video_frame_normalizer.sv | 235 +++++++++++++++++++++++
 tb/tb_axi4s_video_frame_normalizer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4s_video_frame_normalizer.sv
`default_nettype none
// ============================================================================
// Module  : axi4s_video_frame_normalizer
// Brief   : Forces every AXI4-Stream video frame to exactly W x H pixels by
//           dropping pre-SOF beats, padding short lines/frames and truncating
//           long lines, with one-cycle error pulses and a completed-frame count.
// Revision: 1.0  initial release
// ============================================================================
module axi4s_video_frame_normalizer #(
  parameter int                   DATA_BITS   = 10,
  parameter int                   WIDTH_BITS  = 16,
  parameter int                   HEIGHT_BITS = 16,
  parameter logic [DATA_BITS-1:0] PAD_VALUE   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [WIDTH_BITS-1:0]  param_width,
  input  logic [HEIGHT_BITS-1:0] param_height,
  input  logic                   s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [DATA_BITS-1:0]   s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic                   m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [DATA_BITS-1:0]   m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready,
  output logic                   busy,
  output logic                   err_short_line,
  output logic                   err_long_line,
  output logic                   err_short_frame,
  output logic [31:0]            frame_count
);

  localparam logic [WIDTH_BITS-1:0]  c_x_one = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [HEIGHT_BITS-1:0] c_y_one = {{(HEIGHT_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_PAD_LINE  = 3'd2,
    S_SKIP_LINE = 3'd3,
    S_PAD_FRAME = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [WIDTH_BITS-1:0]  r_w, r_x, w_w_nxt, w_x_nxt;
  logic [HEIGHT_BITS-1:0] r_h, r_y, w_h_nxt, w_y_nxt;

  logic                   w_load;
  logic                   w_start;
  logic                   w_mid_sof;
  logic                   w_take;
  logic                   w_emit;
  logic                   w_emit_user;
  logic                   w_emit_last;
  logic [DATA_BITS-1:0]   w_emit_data;
  logic                   w_s_tready;
  logic                   w_err_short_line;
  logic                   w_err_long_line;
  logic                   w_err_short_frame;
  logic                   w_frame_done;

  logic [WIDTH_BITS-1:0]  w_cur_w, w_cur_x;
  logic [HEIGHT_BITS-1:0] w_cur_h, w_cur_y;
  logic                   w_last_x, w_last_y;

  // The output register can take a new beat when empty or being drained.
  assign w_load = !m_axi4s_tvalid || m_axi4s_tready;

  assign w_start = (r_state == S_IDLE) && s_axi4s_tvalid && s_axi4s_tuser && enable &&
                   (param_width != '0) && (param_height != '0);

  assign w_mid_sof = (r_state == S_RUN) && s_axi4s_tvalid && s_axi4s_tuser &&
                     !((r_x == '0) && (r_y == '0));

  // A starting SOF beat is pixel (0,0) of a frame whose geometry is not yet latched.
  assign w_cur_w = w_start ? param_width  : r_w;
  assign w_cur_h = w_start ? param_height : r_h;
  assign w_cur_x = w_start ? '0 : r_x;
  assign w_cur_y = w_start ? '0 : r_y;

  assign w_last_x    = (w_cur_x == (w_cur_w - c_x_one));
  assign w_last_y    = (w_cur_y == (w_cur_h - c_y_one));
  assign w_emit_user = (w_cur_x == '0) && (w_cur_y == '0);

  always_comb begin
    w_state_nxt       = r_state;
    w_x_nxt           = r_x;
    w_y_nxt           = r_y;
    w_w_nxt           = r_w;
    w_h_nxt           = r_h;
    w_s_tready        = 1'b0;
    w_take            = 1'b0;
    w_emit            = 1'b0;
    w_emit_data       = PAD_VALUE;
    w_emit_last       = 1'b0;
    w_err_short_line  = 1'b0;
    w_err_long_line   = 1'b0;
    w_err_short_frame = 1'b0;
    w_frame_done      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // Hold an acceptable SOF until the output register has room.
        w_s_tready = w_load || !w_start;
        if (w_start && w_load) begin
          w_take  = 1'b1;
          w_w_nxt = param_width;
          w_h_nxt = param_height;
        end
      end

      S_RUN: begin
        if (w_mid_sof) begin
          w_err_short_frame = 1'b1;
          w_state_nxt       = S_PAD_FRAME;
        end else begin
          w_s_tready = w_load;
          w_take     = w_load && s_axi4s_tvalid;
        end
      end

      S_PAD_LINE, S_PAD_FRAME: begin
        if (w_load) begin
          w_emit      = 1'b1;
          w_emit_last = w_last_x;
          if (w_last_x) begin
            w_x_nxt = '0;
            if (w_last_y) begin
              w_frame_done = 1'b1;
              w_state_nxt  = S_IDLE;
            end else begin
              w_y_nxt = r_y + c_y_one;
              if (r_state == S_PAD_LINE) w_state_nxt = S_RUN;
            end
          end else begin
            w_x_nxt = r_x + c_x_one;
          end
        end
      end

      S_SKIP_LINE: begin
        // A new SOF is left on the bus so the frame can be closed out first.
        w_s_tready = !(s_axi4s_tvalid && s_axi4s_tuser);
        if (s_axi4s_tvalid && (s_axi4s_tuser || s_axi4s_tlast)) begin
          w_x_nxt = '0;
          if (w_last_y) begin
            w_frame_done = 1'b1;
            w_state_nxt  = S_IDLE;
          end else begin
            w_y_nxt     = r_y + c_y_one;
            w_state_nxt = s_axi4s_tuser ? S_PAD_FRAME : S_RUN;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    if (w_take) begin
      w_emit      = 1'b1;
      w_emit_data = s_axi4s_tdata;
      w_emit_last = w_last_x;
      w_y_nxt     = w_cur_y;
      if (s_axi4s_tlast && !w_last_x) begin
        w_err_short_line = 1'b1;
        w_x_nxt          = w_cur_x + c_x_one;
        w_state_nxt      = S_PAD_LINE;
      end else if (w_last_x && !s_axi4s_tlast) begin
        w_err_long_line = 1'b1;
        w_x_nxt         = w_cur_x;
        w_state_nxt     = S_SKIP_LINE;
      end else if (w_last_x) begin
        w_x_nxt = '0;
        if (w_last_y) begin
          w_frame_done = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_y_nxt     = w_cur_y + c_y_one;
          w_state_nxt = S_RUN;
        end
      end else begin
        w_x_nxt     = w_cur_x + c_x_one;
        w_state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_x             <= '0;
      r_y             <= '0;
      r_w             <= '0;
      r_h             <= '0;
      m_axi4s_tvalid  <= 1'b0;
      m_axi4s_tuser   <= 1'b0;
      m_axi4s_tlast   <= 1'b0;
      m_axi4s_tdata   <= '0;
      err_short_line  <= 1'b0;
      err_long_line   <= 1'b0;
      err_short_frame <= 1'b0;
      frame_count     <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_x             <= w_x_nxt;
      r_y             <= w_y_nxt;
      r_w             <= w_w_nxt;
      r_h             <= w_h_nxt;
      err_short_line  <= w_err_short_line;
      err_long_line   <= w_err_long_line;
      err_short_frame <= w_err_short_frame;
      if (w_frame_done) frame_count <= frame_count + 32'd1;
      if (w_load) begin
        m_axi4s_tvalid <= w_emit;
        if (w_emit) begin
          m_axi4s_tdata <= w_emit_data;
          m_axi4s_tuser <= w_emit_user;
          m_axi4s_tlast <= w_emit_last;
        end else begin
          m_axi4s_tuser <= 1'b0;
          m_axi4s_tlast <= 1'b0;
        end
      end
    end
  end

  assign s_axi4s_tready = w_s_tready;
  assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi4s_video_frame_normalizer.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi4s_video_frame_normalizer
// Brief   : Randomized bench comparing the normalizer against a stream-parsing
//           reference model of the frame rules.
// Revision: 1.0  initial release
// ============================================================================
module tb_axi4s_video_frame_normalizer;

  localparam int              DB   = 10;
  localparam int              WB   = 16;
  localparam int              HB   = 16;
  localparam logic [DB-1:0]   PADV = 10'h2A5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic [WB-1:0] param_width = 16'd4;
  logic [HB-1:0] param_height = 16'd3;
  logic          s_axi4s_tuser = 1'b0, s_axi4s_tlast = 1'b0, s_axi4s_tvalid = 1'b0;
  logic [DB-1:0] s_axi4s_tdata = '0;
  logic          s_axi4s_tready;
  logic          m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tvalid;
  logic [DB-1:0] m_axi4s_tdata;
  logic          m_axi4s_tready = 1'b1;
  logic          busy, err_short_line, err_long_line, err_short_frame;
  logic [31:0]   frame_count;

  axi4s_video_frame_normalizer #(
    .DATA_BITS(DB), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .PAD_VALUE(PADV)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .param_width(param_width), .param_height(param_height),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
    .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready),
    .busy(busy), .err_short_line(err_short_line), .err_long_line(err_long_line),
    .err_short_frame(err_short_frame), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Beats are packed as {tuser, tlast, tdata}.
  logic [DB+1:0] in_q[$];
  logic [DB+1:0] exp_q[$];
  logic [DB+1:0] out_q[$];
  int checks = 0, errors = 0;
  int m_sl, m_ll, m_sf, m_fr;
  int d_sl, d_ll, d_sf;
  int cyc = 0, stalls = 0;
  int first_acc_cyc = -1, first_out_cyc = -2;
  bit rand_ready = 0;
  logic [31:0] exp_fc = 0;

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(negedge clk);
    m_axi4s_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial forever begin
    @(negedge clk); #2;
    if (!reset) begin
      if (m_axi4s_tvalid && m_axi4s_tready) begin
        if (out_q.size() == 0) first_out_cyc = cyc;
        out_q.push_back({m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata});
      end
      d_sl += int'(err_short_line);
      d_ll += int'(err_long_line);
      d_sf += int'(err_short_frame);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_sb();
    in_q.delete(); exp_q.delete(); out_q.delete();
    m_sl = 0; m_ll = 0; m_sf = 0; m_fr = 0;
    d_sl = 0; d_ll = 0; d_sf = 0; stalls = 0;
    first_acc_cyc = -1; first_out_cyc = -2;
  endtask

  task automatic add_line(input int len, input bit sof, input bit with_last);
    for (int k = 0; k < len; k++)
      in_q.push_back({sof && (k == 0), with_last && (k == len - 1), DB'($urandom)});
  endtask

  task automatic gen_frame(input int w, input int h, input bit clean);
    int r, len;
    bit first;
    first = 1;
    for (int y = 0; y < h; y++) begin
      r = clean ? 7 : $urandom_range(0, 7);
      if (r == 0 && w > 1) begin
        len = $urandom_range(1, w - 1); add_line(len, first, 1);
      end else if (r == 1) begin
        len = w + $urandom_range(1, 2); add_line(len, first, 1);
      end else if (r == 2) begin
        len = $urandom_range(0, w - 1); add_line(len, first, 0); return;
      end else if (r == 3) begin
        add_line(w + 1, first, 0); return;
      end else begin
        add_line(w, first, 1);
      end
      first = 0;
    end
  endtask

  task automatic exp_push(input logic [DB-1:0] d, input int pix, input int w);
    exp_q.push_back({pix == 0, (pix % w) == (w - 1), d});
  endtask

  // Parse the input stream line by line into frames of exactly w x h pixels.
  task automatic run_model(input int w, input int h);
    int i, n, pix, cnt;
    bit ended, sof, fin, exh;
    i = 0; n = in_q.size();
    while (i < n) begin
      if (!in_q[i][DB+1]) begin i++; continue; end
      pix = 0; fin = 0; exh = 0;
      while (!fin && !exh) begin
        cnt = 0; ended = 0; sof = 0;
        while (i < n && !ended && !sof) begin
          if (in_q[i][DB+1] && (pix != 0 || cnt != 0)) sof = 1;
          else begin
            if (cnt < w) begin exp_push(in_q[i][DB-1:0], pix, w); pix++; end
            cnt++;
            ended = in_q[i][DB];
            i++;
          end
        end
        if (!ended && !sof) exh = 1;
        else begin
          if (cnt < w && !sof) m_sl++;
          if (cnt < w && sof) m_sf++;
          if (cnt >= w && !(ended && cnt == w)) m_ll++;
          if (sof) while (pix < w * h) begin exp_push(PADV, pix, w); pix++; end
          else while (pix % w != 0) begin exp_push(PADV, pix, w); pix++; end
          if (pix >= w * h) fin = 1;
        end
      end
      if (fin) m_fr++;
    end
  endtask

  task automatic drive_stream(input int nbeats);
    int waitc;
    for (int k = 0; k < nbeats; k++) begin
      waitc = 0;
      @(negedge clk);
      {s_axi4s_tuser, s_axi4s_tlast, s_axi4s_tdata} = in_q[k];
      s_axi4s_tvalid = 1'b1;
      #1;
      while (!s_axi4s_tready) begin
        stalls++; waitc++;
        if (waitc > 300) begin
          checks++; errors++;
          $display("FAIL drive_timeout beat %0d not accepted, tready=%b expected 1", k, s_axi4s_tready);
          s_axi4s_tvalid = 1'b0;
          return;
        end
        @(negedge clk); #1;
      end
      if (k == 0) first_acc_cyc = cyc + 1;
    end
    @(negedge clk);
    s_axi4s_tvalid = 1'b0; s_axi4s_tuser = 1'b0; s_axi4s_tlast = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (out_q.size() < exp_q.size() && t < 600) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata} !== '0) begin
      errors++;
      $display("FAIL reset_m_side got v=%b u=%b l=%b d=%h expected all 0",
               m_axi4s_tvalid, m_axi4s_tuser, m_axi4s_tlast, m_axi4s_tdata);
    end
    checks++;
    if ({busy, err_short_line, err_long_line, err_short_frame} !== 4'b0 || frame_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_status got busy=%b errs=%b%b%b fc=%0d expected 0", busy,
               err_short_line, err_long_line, err_short_frame, frame_count);
    end
    checks++;
    if (s_axi4s_tready !== 1'b1) begin
      errors++; $display("FAIL reset_idle_tready got %b expected 1", s_axi4s_tready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean();
    clear_sb(); rand_ready = 0;
    param_width = 16'd4; param_height = 16'd3;
    gen_frame(4, 3, 1);
    run_model(4, 3); exp_fc += 32'(m_fr);
    drive_stream(in_q.size()); drain();
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL clean_count got %0d expected %0d", out_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      checks++;
      if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL clean_beat[%0d] got %h expected %h", k,
                           (k < out_q.size()) ? out_q[k] : '1, exp_q[k]);
      end
    end
    checks++;
    if (first_out_cyc != first_acc_cyc) begin
      errors++; $display("FAIL clean_latency got out cycle %0d expected %0d", first_out_cyc, first_acc_cyc);
    end
    checks++;
    if (frame_count !== exp_fc || d_sl + d_ll + d_sf != 0 || stalls != 0) begin
      errors++; $display("FAIL clean_status got fc=%0d errs=%0d stalls=%0d expected fc=%0d errs=0 stalls=0",
                         frame_count, d_sl + d_ll + d_sf, stalls, exp_fc);
    end
  endtask

  task automatic test_pre_sof_garbage();
    clear_sb(); rand_ready = 0;
    for (int k = 0; k < 5; k++) in_q.push_back({1'b0, 1'($urandom_range(0, 1)), DB'($urandom)});
    gen_frame(4, 3, 1);
    run_model(4, 3); exp_fc += 32'(m_fr);
    drive_stream(in_q.size()); drain();
    checks++;
    if (out_q.size() != 12 || out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL garbage_count got %0d expected 12", out_q.size());
    end
    foreach (exp_q[k]) begin
      checks++;
      if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL garbage_beat[%0d] got %h expected %h", k,
                           (k < out_q.size()) ? out_q[k] : '1, exp_q[k]);
      end
    end
    checks++;
    if (stalls != 0 || frame_count !== exp_fc) begin
      errors++; $display("FAIL garbage_status got stalls=%0d fc=%0d expected stalls=0 fc=%0d",
                         stalls, frame_count, exp_fc);
    end
  endtask

  task automatic test_line_errors(input bit is_long);
    clear_sb(); rand_ready = 0;
    if (is_long) begin add_line(6, 1, 1); add_line(4, 0, 1); end
    else         begin add_line(4, 1, 1); add_line(2, 0, 1); end
    add_line(4, 0, 1);
    if (is_long) add_line(4, 0, 1);
    run_model(4, 3); exp_fc += 32'(m_fr);
    drive_stream(in_q.size()); drain();
    checks++;
    if (out_q.size() != 12 || out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL line%0d_count got %0d expected 12", is_long, out_q.size());
    end
    foreach (exp_q[k]) begin
      checks++;
      if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL line%0d_beat[%0d] got %h expected %h", is_long, k,
                           (k < out_q.size()) ? out_q[k] : '1, exp_q[k]);
      end
    end
    checks++;
    if (d_sl != (is_long ? 0 : 1) || d_ll != (is_long ? 1 : 0) || d_sf != 0 || frame_count !== exp_fc) begin
      errors++; $display("FAIL line%0d_errs got sl=%0d ll=%0d sf=%0d fc=%0d expected sl=%0d ll=%0d sf=0 fc=%0d",
                         is_long, d_sl, d_ll, d_sf, frame_count, !is_long, is_long, exp_fc);
    end
  endtask

  task automatic test_short_frame();
    clear_sb(); rand_ready = 0;
    add_line(4, 1, 1); add_line(1, 0, 0);
    gen_frame(4, 3, 1);
    run_model(4, 3); exp_fc += 32'(m_fr);
    drive_stream(in_q.size()); drain();
    checks++;
    if (out_q.size() != 24 || out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL sframe_count got %0d expected 24", out_q.size());
    end
    foreach (exp_q[k]) begin
      checks++;
      if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL sframe_beat[%0d] got %h expected %h", k,
                           (k < out_q.size()) ? out_q[k] : '1, exp_q[k]);
      end
    end
    checks++;
    if (d_sf != 1 || d_sl != 0 || d_ll != 0 || m_fr != 2 || frame_count !== exp_fc) begin
      errors++; $display("FAIL sframe_status got sf=%0d sl=%0d ll=%0d fc=%0d expected sf=1 sl=0 ll=0 fc=%0d",
                         d_sf, d_sl, d_ll, frame_count, exp_fc);
    end
  endtask

  task automatic test_enable_off();
    clear_sb(); rand_ready = 0; enable = 1'b0;
    gen_frame(4, 3, 1);
    drive_stream(in_q.size()); drain();
    checks++;
    if (out_q.size() != 0 || stalls != 0 || frame_count !== exp_fc || busy !== 1'b0) begin
      errors++; $display("FAIL enable_off got beats=%0d stalls=%0d fc=%0d busy=%b expected 0,0,%0d,0",
                         out_q.size(), stalls, frame_count, busy, exp_fc);
    end
    enable = 1'b1;
  endtask

  task automatic test_random_frames();
    int w, h;
    for (int it = 0; it < 4; it++) begin
      clear_sb(); rand_ready = 1;
      w = $urandom_range(1, 5); h = $urandom_range(1, 4);
      param_width = WB'(w); param_height = HB'(h);
      for (int f = 0; f < 3; f++) gen_frame(w, h, 0);
      gen_frame(w, h, 1);
      run_model(w, h); exp_fc += 32'(m_fr);
      drive_stream(in_q.size()); drain();
      checks++;
      if (out_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count W=%0d H=%0d got %0d expected %0d", it, w, h,
                           out_q.size(), exp_q.size());
      end
      foreach (exp_q[k]) begin
        checks++;
        if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand%0d_beat[%0d] got %h expected %h", it, k,
                             (k < out_q.size()) ? out_q[k] : '1, exp_q[k]);
        end
      end
      checks++;
      if (d_sl != m_sl || d_ll != m_ll || d_sf != m_sf || frame_count !== exp_fc) begin
        errors++; $display("FAIL rand%0d_status got sl=%0d ll=%0d sf=%0d fc=%0d expected %0d %0d %0d %0d",
                           it, d_sl, d_ll, d_sf, frame_count, m_sl, m_ll, m_sf, exp_fc);
      end
    end
  endtask

  task automatic test_backpressure_reset();
    clear_sb(); rand_ready = 1;
    param_width = 16'd4; param_height = 16'd3;
    gen_frame(4, 3, 1);
    run_model(4, 3); exp_fc += 32'(m_fr);
    drive_stream(in_q.size()); drain();
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count got %0d expected %0d", out_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      checks++;
      if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL bp_beat[%0d] got %h expected %h", k,
                           (k < out_q.size()) ? out_q[k] : '1, exp_q[k]);
      end
    end
    // Abort the next frame partway through.
    clear_sb();
    gen_frame(4, 3, 1);
    drive_stream(6);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (m_axi4s_tvalid !== 1'b0 || frame_count !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL midreset got tvalid=%b fc=%0d busy=%b expected 0,0,0",
                         m_axi4s_tvalid, frame_count, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_fc = 0;
    clear_sb();
    gen_frame(4, 3, 1);
    run_model(4, 3); exp_fc += 32'(m_fr);
    drive_stream(in_q.size()); drain();
    checks++;
    if (out_q.size() != exp_q.size()) begin
      errors++; $display("FAIL postreset_count got %0d expected %0d", out_q.size(), exp_q.size());
    end
    foreach (exp_q[k]) begin
      checks++;
      if (k >= out_q.size() || out_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL postreset_beat[%0d] got %h expected %h", k,
                           (k < out_q.size()) ? out_q[k] : '1, exp_q[k]);
      end
    end
    checks++;
    if (frame_count !== exp_fc || d_sl + d_ll + d_sf != 0) begin
      errors++; $display("FAIL postreset_status got fc=%0d errs=%0d expected fc=%0d errs=0",
                         frame_count, d_sl + d_ll + d_sf, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_pre_sof_garbage();
    test_line_errors(1'b0);
    test_line_errors(1'b1);
    test_short_frame();
    test_enable_off();
    test_random_frames();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
